roce_tx_payload_framer: RTL and testbench

ROCE_TX_PAYLOAD_FRAMER -- requirements
Module: roce_tx_payload_framer

---
 rtl/roce_tx_payload_framer.sv | 181 ++++++++++++++++++
 tb/tb_roce_tx_payload_framer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/roce_tx_payload_framer.sv
// rtl/roce_tx_payload_framer.sv - RoCE TX payload framer: trims/terminates DMA payload to the commanded length
//
// Optional feature macro: ROCE_TX_FRAMER_STATS_EN (adds saturating stat counters)
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   s_cmd_valid/ready/length    DMA command (transfer length in bytes)
//   s_axis_t*                   raw payload from DMA
//   m_axis_t*                   framed payload towards the RoCE TX header producer
//   busy                        high while a command is being framed or drained
//   error_*                     single-cycle error pulses, registered
//   stat_* (macro only)         frames completed, early terminations, overruns
module roce_tx_payload_framer #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_cmd_valid,
  output logic                  s_cmd_ready,
  input  logic [LEN_WIDTH-1:0]  s_cmd_length,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  error_payload_early_termination,
  output logic                  error_payload_overrun,
  output logic                  error_zero_length
`ifdef ROCE_TX_FRAMER_STATS_EN
  ,
  output logic [31:0]           stat_frames,
  output logic [31:0]           stat_early_term,
  output logic [31:0]           stat_overrun
`endif
);

  localparam int CNT_W = $clog2(KEEP_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] remaining, remaining_nxt;
  logic [CNT_W-1:0]     beat_bytes;
  logic                 ones_run;
  logic [KEEP_WIDTH-1:0] rem_mask;
  logic                 final_beat;
  logic                 xfer;
  logic                 ovr_nxt, early_nxt, zero_nxt, frame_done;

  // Byte count is the run of contiguous ones from bit 0; holes end the count.
  always_comb begin
    beat_bytes = '0;
    ones_run   = 1'b1;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (ones_run && s_axis_tkeep[i]) beat_bytes = beat_bytes + CNT_W'(1);
      else                             ones_run   = 1'b0;
    end
  end

  // Keep mask for the last beat: low "remaining" bytes valid.
  always_comb begin
    rem_mask = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      rem_mask[i] = (LEN_WIDTH'(i) < remaining);
    end
  end

  assign final_beat = (remaining <= LEN_WIDTH'(beat_bytes));
  assign xfer       = s_axis_tvalid && m_axis_tready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    s_cmd_ready   = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = s_axis_tdata;
    m_axis_tkeep  = s_axis_tkeep;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    ovr_nxt       = 1'b0;
    early_nxt     = 1'b0;
    zero_nxt      = 1'b0;
    frame_done    = 1'b0;
    case (state)
      IDLE: begin
        s_cmd_ready = 1'b1;
        if (s_cmd_valid) begin
          if (s_cmd_length == '0) begin
            zero_nxt = 1'b1;
          end else begin
            remaining_nxt = s_cmd_length;
            state_nxt     = PASS;
          end
        end
      end
      PASS: begin
        // Zero-latency pass-through; tkeep/tlast/tuser are stable while the
        // beat is offered so a stalled output never changes under the sink.
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        m_axis_tuser  = s_axis_tuser;
        if (final_beat) begin
          m_axis_tkeep = rem_mask;
          m_axis_tlast = 1'b1;
          if (xfer) begin
            remaining_nxt = '0;
            frame_done    = 1'b1;
            if (s_axis_tlast) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = DROP;
              ovr_nxt   = 1'b1;
            end
          end
        end else if (s_axis_tlast) begin
          m_axis_tlast = 1'b1;
          m_axis_tuser = 1'b1;
          if (xfer) begin
            remaining_nxt = '0;
            frame_done    = 1'b1;
            early_nxt     = 1'b1;
            state_nxt     = IDLE;
          end
        end else if (xfer) begin
          remaining_nxt = remaining - LEN_WIDTH'(beat_bytes);
        end
      end
      DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining                       <= '0;
      error_payload_early_termination <= 1'b0;
      error_payload_overrun           <= 1'b0;
      error_zero_length               <= 1'b0;
    end else begin
      remaining                       <= remaining_nxt;
      error_payload_early_termination <= early_nxt;
      error_payload_overrun           <= ovr_nxt;
      error_zero_length               <= zero_nxt;
    end
  end

`ifdef ROCE_TX_FRAMER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frames     <= '0;
      stat_early_term <= '0;
      stat_overrun    <= '0;
    end else begin
      if (frame_done && stat_frames != '1)     stat_frames     <= stat_frames + 32'd1;
      if (early_nxt  && stat_early_term != '1) stat_early_term <= stat_early_term + 32'd1;
      if (ovr_nxt    && stat_overrun != '1)    stat_overrun    <= stat_overrun + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_roce_tx_payload_framer.sv
// tb/tb_roce_tx_payload_framer.sv - directed self-checking bench for roce_tx_payload_framer
module tb_roce_tx_payload_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_cmd_valid = 1'b0;
  logic        s_cmd_ready;
  logic [31:0] s_cmd_length = '0;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        busy;
  logic        error_payload_early_termination;
  logic        error_payload_overrun;
  logic        error_zero_length;

  always #5 clk = ~clk;

  roce_tx_payload_framer dut (
    .clk                             (clk),
    .rst                             (rst),
    .s_cmd_valid                     (s_cmd_valid),
    .s_cmd_ready                     (s_cmd_ready),
    .s_cmd_length                    (s_cmd_length),
    .s_axis_tdata                    (s_axis_tdata),
    .s_axis_tkeep                    (s_axis_tkeep),
    .s_axis_tvalid                   (s_axis_tvalid),
    .s_axis_tready                   (s_axis_tready),
    .s_axis_tlast                    (s_axis_tlast),
    .s_axis_tuser                    (s_axis_tuser),
    .m_axis_tdata                    (m_axis_tdata),
    .m_axis_tkeep                    (m_axis_tkeep),
    .m_axis_tvalid                   (m_axis_tvalid),
    .m_axis_tready                   (m_axis_tready),
    .m_axis_tlast                    (m_axis_tlast),
    .m_axis_tuser                    (m_axis_tuser),
    .busy                            (busy),
    .error_payload_early_termination (error_payload_early_termination),
    .error_payload_overrun           (error_payload_overrun),
    .error_zero_length               (error_zero_length)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Output monitor and pulse counters, sampled on the falling edge.
  logic [63:0] od[$];
  logic [7:0]  okp[$];
  logic        ol[$];
  logic        ou[$];
  int n_over = 0, n_early = 0, n_zero = 0, n_sxfer = 0;

  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      od.push_back(m_axis_tdata);
      okp.push_back(m_axis_tkeep);
      ol.push_back(m_axis_tlast);
      ou.push_back(m_axis_tuser);
    end
    if (error_payload_overrun)           n_over++;
    if (error_payload_early_termination) n_early++;
    if (error_zero_length)               n_zero++;
    if (s_axis_tvalid && s_axis_tready)  n_sxfer++;
  end

  // Sink backpressure: always ready, or the 1,1,0,0,1,1,1,1 pattern.
  logic       toggle = 1'b0;
  logic [7:0] pat = 8'b1111_0011;
  int         phase = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle) begin
        m_axis_tready = pat[phase];
        phase = (phase + 1) % 8;
      end else begin
        m_axis_tready = 1'b1;
      end
    end
  end

  task automatic send_cmd(input logic [31:0] len);
    bit done = 0;
    s_cmd_valid  = 1'b1;
    s_cmd_length = len;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (s_cmd_ready) done = 1;
      @(posedge clk);
      #1;
    end
    s_cmd_valid = 1'b0;
    if (!done) check("cmd_timeout", 1, 0);
  endtask

  // Beat b (1-based) carries {fid, b}; tlast on beat tlast_beat (0 = never).
  task automatic send_frame(input int fid, input int n, input logic [7:0] last_keep, input int tlast_beat);
    for (int b = 1; b <= n; b++) begin
      bit done = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {fid[31:0], b[31:0]};
      s_axis_tkeep  = (b == n) ? last_keep : 8'hFF;
      s_axis_tlast  = (b == tlast_beat);
      for (int c = 0; c < 1000 && !done; c++) begin
        @(negedge clk);
        if (s_axis_tready) done = 1;
        @(posedge clk);
        #1;
      end
      if (!done) begin
        check("beat_timeout", 1, 0);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int base, input int n_exp, input int fid,
                             input logic [7:0] last_keep, input logic last_user);
    int got_n = od.size() - base;
    int derr = 0, merr = 0;
    check({tag, "_beats"}, got_n, n_exp);
    if (got_n == n_exp && n_exp > 0) begin
      for (int k = 0; k < n_exp; k++) begin
        logic [31:0] idx = k + 1;
        if (od[base+k] !== {fid[31:0], idx}) derr++;
        if (k < n_exp - 1 && (ol[base+k] !== 1'b0 || okp[base+k] !== 8'hFF || ou[base+k] !== 1'b0)) merr++;
      end
      check({tag, "_data_err"}, derr, 0);
      check({tag, "_mid_err"}, merr, 0);
      check({tag, "_last_keep"}, okp[base+n_exp-1], last_keep);
      check({tag, "_last_tlast"}, ol[base+n_exp-1], 1);
      check({tag, "_last_tuser"}, ou[base+n_exp-1], last_user);
    end
  endtask

  initial begin
    int b, o, e, z, sx, tl;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", s_cmd_ready, 1);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_m_tuser", m_axis_tuser, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 3200 bytes, 400 full beats
    b = od.size(); o = n_over; e = n_early;
    send_cmd(3200);
    send_frame(1, 400, 8'hFF, 400);
    @(negedge clk);
    check("t030_busy_after", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check_frame("t030", b, 400, 1, 8'hFF, 1'b0);
    check("t030_overrun", n_over - o, 0);
    check("t030_early", n_early - e, 0);

    // 3203 bytes, short last beat
    b = od.size(); o = n_over; e = n_early;
    send_cmd(3203);
    send_frame(2, 401, 8'h07, 401);
    repeat (3) @(posedge clk);
    #1;
    check_frame("t031", b, 401, 2, 8'h07, 1'b0);
    check("t031_errors", (n_over - o) + (n_early - e), 0);

    // 20 bytes against a 10-beat payload: overrun, tail dropped
    b = od.size(); o = n_over; sx = n_sxfer;
    send_cmd(20);
    send_frame(3, 10, 8'hFF, 10);
    @(negedge clk);
    check("t032_busy_after", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check_frame("t032", b, 3, 3, 8'h0F, 1'b0);
    check("t032_overrun", n_over - o, 1);
    check("t032_in_beats", n_sxfer - sx, 10);

    // 64 bytes, payload ends after 4 beats
    b = od.size(); o = n_over; e = n_early;
    send_cmd(64);
    send_frame(4, 4, 8'hFF, 4);
    repeat (3) @(posedge clk);
    #1;
    check_frame("t033", b, 4, 4, 8'hFF, 1'b1);
    check("t033_early", n_early - e, 1);
    check("t033_overrun", n_over - o, 0);
    check("t033_busy", busy, 0);

    // 3200 bytes under toggling backpressure
    b = od.size();
    toggle = 1'b1;
    send_cmd(3200);
    send_frame(5, 400, 8'hFF, 400);
    toggle = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_frame("t034", b, 400, 5, 8'hFF, 1'b0);

    // zero-length command
    b = od.size(); z = n_zero;
    send_cmd(0);
    repeat (3) @(posedge clk);
    #1;
    check("t035_zero_pulse", n_zero - z, 1);
    check("t035_zero_no_out", od.size() - b, 0);
    check("t035_zero_busy", busy, 0);

    // reset mid-frame, then a clean 16-byte frame
    b = od.size();
    send_cmd(800);
    send_frame(7, 5, 8'hFF, 0);
    rst = 1'b1;
    @(negedge clk);
    check("t035_rst_busy", busy, 0);
    check("t035_rst_cmd_ready", s_cmd_ready, 1);
    check("t035_rst_m_tvalid", m_axis_tvalid, 0);
    tl = 0;
    for (int k = b; k < od.size(); k++) if (ol[k] !== 1'b0) tl++;
    check("t035_rst_beats", od.size() - b, 5);
    check("t035_rst_no_tlast", tl, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    b = od.size();
    send_cmd(16);
    send_frame(8, 2, 8'hFF, 2);
    repeat (3) @(posedge clk);
    #1;
    check_frame("t035_after_rst", b, 2, 8, 8'hFF, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
